// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, mux selects,
// opcode/funct values and ALU op codes.
package multicycle_controller_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ITYPE  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_FUNCT,
        CLS_OP
    } alu_cls_t;

    localparam logic [1:0] SRCA_PC = 2'b00;
    localparam logic [1:0] SRCA_A  = 2'b10;
    localparam logic [1:0] SRCA_B  = 2'b11;

    localparam logic [2:0] SRCB_B     = 3'b000;
    localparam logic [2:0] SRCB_FOUR  = 3'b001;
    localparam logic [2:0] SRCB_IMM   = 3'b010;
    localparam logic [2:0] SRCB_SHAMT = 3'b011;
    localparam logic [2:0] SRCB_IMM2  = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_DATA   = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // R-type ALU functs that execute through EXEC (jr is dispatched apart)
    function automatic logic funct_ok(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT:  funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [5:0] fn);
        is_shift = (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields in, datapath selects and enables out.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [5:0]              Opcode;
    logic [5:0]              Funct;
    logic                    IorD;
    logic [1:0]              ALUSrcA;
    logic [2:0]              ALUSrcB;
    logic [1:0]              PCSrc;
    logic [1:0]              RegDst;
    logic [1:0]              MemtoReg;
    logic [1:0]              Branch;
    logic                    IRWrite;
    logic                    MemWrite;
    logic                    PCWrite;
    logic                    RegWrite;
    logic [ALU_OP_WIDTH-1:0] ALUControl;
    logic                    Illegal;

    modport master (
        input  Opcode, Funct,
        output IorD, ALUSrcA, ALUSrcB, PCSrc,
        output RegDst, MemtoReg, Branch,
        output IRWrite, MemWrite, PCWrite, RegWrite,
        output ALUControl, Illegal
    );

    modport slave (
        output Opcode, Funct,
        input  IorD, ALUSrcA, ALUSrcB, PCSrc,
        input  RegDst, MemtoReg, Branch,
        input  IRWrite, MemWrite, PCWrite, RegWrite,
        input  ALUControl, Illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the state's ALU class plus Opcode/Funct to an ALU operation code.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_cls_t                cls,
    input  logic [5:0]              opcode,
    input  logic [5:0]              funct,
    output logic [ALU_OP_WIDTH-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        unique case (cls)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_FUNCT: begin
                case (funct)
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    default:         alu_op = ALU_ADD;
                endcase
            end
            CLS_OP: begin
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_XORI: alu_op = ALU_XOR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM. Define CONTROL_ILLEGAL_TRAP_EN to halt on
// unrecognised instructions instead of treating them as 2-cycle NOPs.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input logic                  clk,
    input logic                  rstb,
    multicycle_controller_if.master ctl
);

`ifdef CONTROL_ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = S_HALT;
`else
    localparam state_t ILL_NEXT = S_FETCH;
`endif

    state_t   state;
    alu_cls_t cls;

    function automatic state_t dispatch(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        case (op)
            OP_R: begin
                if (fn == FN_JR)
                    dispatch = S_JR;
                else if (funct_ok(fn))
                    dispatch = S_EXEC;
                else
                    dispatch = ILL_NEXT;
            end
            OP_LW, OP_SW:       dispatch = S_MEMADR;
            OP_ADDI, OP_ADDIU,
            OP_ANDI, OP_ORI,
            OP_XORI, OP_SLTI:   dispatch = S_ITYPE;
            OP_BEQ, OP_BNE:     dispatch = S_BRANCH;
            OP_J:               dispatch = S_JUMP;
            OP_JAL:             dispatch = S_JAL;
            default:            dispatch = ILL_NEXT;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_RESET;
        end else begin
            unique case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= dispatch(ctl.Opcode, ctl.Funct);
                S_MEMADR: state <= (ctl.Opcode == OP_SW) ?
                                   S_MEMWR : S_MEMRD;
                S_MEMRD:  state <= S_MEMWB;
                S_EXEC:   state <= S_ALUWB;
                S_ITYPE:  state <= S_IWB;
                S_MEMWB,
                S_MEMWR,
                S_ALUWB,
                S_IWB,
                S_BRANCH,
                S_JUMP,
                S_JAL,
                S_JR:     state <= S_FETCH;
                S_HALT:   state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        ctl.IorD     = 1'b0;
        ctl.ALUSrcA  = SRCA_PC;
        ctl.ALUSrcB  = SRCB_B;
        ctl.PCSrc    = PCSRC_ALU;
        ctl.RegDst   = REGDST_RT;
        ctl.MemtoReg = M2R_ALUOUT;
        ctl.Branch   = BR_NONE;
        ctl.IRWrite  = 1'b0;
        ctl.MemWrite = 1'b0;
        ctl.PCWrite  = 1'b0;
        ctl.RegWrite = 1'b0;
        cls          = CLS_ADD;
        unique case (state)
            S_FETCH: begin
                ctl.ALUSrcB = SRCB_FOUR;
                ctl.IRWrite = 1'b1;
                ctl.PCWrite = 1'b1;
            end
            S_DECODE: ctl.ALUSrcB = SRCB_IMM2;
            S_MEMADR: begin
                ctl.ALUSrcA = SRCA_A;
                ctl.ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: ctl.IorD = 1'b1;
            S_MEMWB: begin
                ctl.MemtoReg = M2R_DATA;
                ctl.RegWrite = 1'b1;
            end
            S_MEMWR: begin
                ctl.IorD     = 1'b1;
                ctl.MemWrite = 1'b1;
            end
            S_EXEC: begin
                cls = CLS_FUNCT;
                if (is_shift(ctl.Funct)) begin
                    ctl.ALUSrcA = SRCA_B;
                    ctl.ALUSrcB = SRCB_SHAMT;
                end else begin
                    ctl.ALUSrcA = SRCA_A;
                end
            end
            S_ALUWB: begin
                ctl.RegDst   = REGDST_RD;
                ctl.RegWrite = 1'b1;
            end
            S_ITYPE: begin
                cls         = CLS_OP;
                ctl.ALUSrcA = SRCA_A;
                ctl.ALUSrcB = SRCB_IMM;
            end
            S_IWB: ctl.RegWrite = 1'b1;
            S_BRANCH: begin
                cls         = CLS_SUB;
                ctl.ALUSrcA = SRCA_A;
                ctl.PCSrc   = PCSRC_ALUOUT;
                ctl.Branch  = (ctl.Opcode == OP_BNE) ?
                              BR_BNE : BR_BEQ;
            end
            S_JUMP: begin
                ctl.PCSrc   = PCSRC_JUMP;
                ctl.PCWrite = 1'b1;
            end
            // PC already holds PC+4, so link and jump share one cycle
            S_JAL: begin
                ctl.RegDst   = REGDST_RA;
                ctl.MemtoReg = M2R_PC;
                ctl.RegWrite = 1'b1;
                ctl.PCSrc    = PCSRC_JUMP;
                ctl.PCWrite  = 1'b1;
            end
            S_JR: begin
                ctl.ALUSrcA = SRCA_A;
                ctl.PCWrite = 1'b1;
            end
            S_RESET, S_HALT: begin
            end
        endcase
    end

    multicycle_controller_alu_decoder u_alu_dec (
        .cls    (cls),
        .opcode (ctl.Opcode),
        .funct  (ctl.Funct),
        .alu_op (ctl.ALUControl)
    );

`ifdef CONTROL_ILLEGAL_TRAP_EN
    assign ctl.Illegal = (state == S_HALT);
`else
    assign ctl.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; every control output is packed
// into one vector and compared against hand-built expectations per cycle.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic clk;
    logic rstb;
    int   checks;
    int   errors;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk  (clk),
        .rstb (rstb),
        .ctl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [22:0] obs;
    assign obs = {bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc,
                  bus.RegDst, bus.MemtoReg, bus.Branch,
                  bus.IRWrite, bus.MemWrite, bus.PCWrite,
                  bus.RegWrite, bus.ALUControl, bus.Illegal};

    function automatic logic [22:0] v(
        input logic       iord,
        input logic [1:0] srca,
        input logic [2:0] srcb,
        input logic [1:0] pcsrc,
        input logic [1:0] regdst,
        input logic [1:0] m2r,
        input logic [1:0] br,
        input logic       irw,
        input logic       memw,
        input logic       pcw,
        input logic       regw,
        input logic [3:0] alu,
        input logic       ill
    );
        v = {iord, srca, srcb, pcsrc, regdst, m2r, br,
             irw, memw, pcw, regw, alu, ill};
    endfunction

    task automatic chk(input string tag, input logic [22:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // check the current cycle, then move to the next sample point
    task automatic at(input string tag, input logic [22:0] e);
        chk(tag, e);
        @(negedge clk);
    endtask

    task automatic set(input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode = op;
        bus.Funct  = fn;
    endtask

    logic [22:0] ZERO, FET, DEC, MADR, MRD, MWB, MWR, AWB, IWB;
    logic [22:0] JMP, JAL_V, JR_V, HALT_V;

    initial begin
        checks = 0;
        errors = 0;
        ZERO   = '0;
        FET    = v(0, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 2'b00,
                   1, 0, 1, 0, ALU_ADD, 0);
        DEC    = v(0, 2'b00, 3'b100, 2'b00, 2'b00, 2'b00, 2'b00,
                   0, 0, 0, 0, ALU_ADD, 0);
        MADR   = v(0, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00, 2'b00,
                   0, 0, 0, 0, ALU_ADD, 0);
        MRD    = v(1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00,
                   0, 0, 0, 0, ALU_ADD, 0);
        MWB    = v(0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00,
                   0, 0, 0, 1, ALU_ADD, 0);
        MWR    = v(1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00,
                   0, 1, 0, 0, ALU_ADD, 0);
        AWB    = v(0, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00, 2'b00,
                   0, 0, 0, 1, ALU_ADD, 0);
        IWB    = v(0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00,
                   0, 0, 0, 1, ALU_ADD, 0);
        JMP    = v(0, 2'b00, 3'b000, 2'b11, 2'b00, 2'b00, 2'b00,
                   0, 0, 1, 0, ALU_ADD, 0);
        JAL_V  = v(0, 2'b00, 3'b000, 2'b11, 2'b10, 2'b10, 2'b00,
                   0, 0, 1, 1, ALU_ADD, 0);
        JR_V   = v(0, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00,
                   0, 0, 1, 0, ALU_ADD, 0);
        HALT_V = v(0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00,
                   0, 0, 0, 0, 4'd0, 1);

        rstb = 1'b0;
        set(6'h00, 6'h20);
        #1;
        chk("rst_t0", ZERO);
        @(negedge clk);
        at("rst_c1", ZERO);
        at("rst_c2", ZERO);
        chk("rst_c3", ZERO);
        rstb = 1'b1;
        @(negedge clk);

        // lw: 5 cycles
        set(6'h23, 6'h00);
        at("lw_fetch", FET);
        at("lw_decode", DEC);
        at("lw_madr", MADR);
        at("lw_memrd", MRD);
        at("lw_memwb", MWB);

        // sw: 4 cycles
        set(6'h2B, 6'h00);
        at("sw_fetch", FET);
        at("sw_decode", DEC);
        at("sw_madr", MADR);
        at("sw_memwr", MWR);

        // sll: shift source selects
        set(6'h00, 6'h00);
        at("sll_fetch", FET);
        at("sll_decode", DEC);
        at("sll_exec", v(0, 2'b11, 3'b011, 2'b00, 2'b00, 2'b00,
                         2'b00, 0, 0, 0, 0, ALU_SLL, 0));
        at("sll_aluwb", AWB);

        set(6'h00, 6'h20);
        at("add_fetch", FET);
        at("add_decode", DEC);
        at("add_exec", v(0, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00,
                         2'b00, 0, 0, 0, 0, ALU_ADD, 0));
        at("add_aluwb", AWB);

        set(6'h00, 6'h22);
        at("sub_fetch", FET);
        at("sub_decode", DEC);
        at("sub_exec", v(0, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00,
                         2'b00, 0, 0, 0, 0, ALU_SUB, 0));
        at("sub_aluwb", AWB);

        set(6'h00, 6'h27);
        at("nor_fetch", FET);
        at("nor_decode", DEC);
        at("nor_exec", v(0, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00,
                         2'b00, 0, 0, 0, 0, ALU_NOR, 0));
        at("nor_aluwb", AWB);

        set(6'h0D, 6'h00);
        at("ori_fetch", FET);
        at("ori_decode", DEC);
        at("ori_itype", v(0, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00,
                          2'b00, 0, 0, 0, 0, ALU_OR, 0));
        at("ori_iwb", IWB);

        set(6'h0A, 6'h00);
        at("slti_fetch", FET);
        at("slti_decode", DEC);
        at("slti_itype", v(0, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00,
                           2'b00, 0, 0, 0, 0, ALU_SLT, 0));
        at("slti_iwb", IWB);

        set(6'h04, 6'h00);
        at("beq_fetch", FET);
        at("beq_decode", DEC);
        at("beq_branch", v(0, 2'b10, 3'b000, 2'b01, 2'b00, 2'b00,
                           2'b01, 0, 0, 0, 0, ALU_SUB, 0));

        set(6'h05, 6'h00);
        at("bne_fetch", FET);
        at("bne_decode", DEC);
        at("bne_branch", v(0, 2'b10, 3'b000, 2'b01, 2'b00, 2'b00,
                           2'b10, 0, 0, 0, 0, ALU_SUB, 0));

        set(6'h02, 6'h00);
        at("j_fetch", FET);
        at("j_decode", DEC);
        at("j_jump", JMP);

        set(6'h03, 6'h00);
        at("jal_fetch", FET);
        at("jal_decode", DEC);
        at("jal_jal", JAL_V);

        set(6'h00, 6'h08);
        at("jr_fetch", FET);
        at("jr_decode", DEC);
        at("jr_jr", JR_V);

        // reset mid-lw, during MEMRD: no writeback may follow
        set(6'h23, 6'h00);
        at("lwr_fetch", FET);
        at("lwr_decode", DEC);
        at("lwr_madr", MADR);
        chk("lwr_memrd", MRD);
        rstb = 1'b0;
        #1;
        chk("lwr_async", ZERO);
        @(negedge clk);
        chk("lwr_held", ZERO);
        rstb = 1'b1;
        @(negedge clk);

        set(6'h3F, 6'h00);
        at("ill_fetch", FET);
        at("ill_decode", DEC);
`ifdef CONTROL_ILLEGAL_TRAP_EN
        at("ill_halt0", HALT_V);
        at("ill_halt1", HALT_V);
        chk("ill_halt2", HALT_V);
        rstb = 1'b0;
        #1;
        chk("ill_rst", ZERO);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        set(6'h02, 6'h00);
        at("post_fetch", FET);
        at("post_decode", DEC);
        at("post_jump", JMP);
        chk("post_ret", FET);
`else
        chk("ill_nop", FET);
        checks++;
        assert (obs[0] === 1'b0) else begin
            errors++;
            $error("FAIL ill_flag: observed %b expected 0", obs[0]);
        end
        set(6'h00, 6'h01);
        @(negedge clk);
        at("illf_decode", DEC);
        at("illf_nop", FET);
        set(6'h02, 6'h00);
        at("post_decode", DEC);
        at("post_jump", JMP);
        chk("post_ret", FET);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
